// File: rtl/ball_stepper.sv
// rtl/ball_stepper.sv - ping-pong ball position stepper with wall bounce and miss detection
module ball_stepper #(
  parameter int unsigned DIV     = 4,
  parameter logic [7:0]  POS_MAX = 8'd200,
  parameter logic [7:0]  POS_CTR = 8'd100
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       serve,
  input  logic       serve_dir,
  input  logic [1:0] speed,
  input  logic       hit_left,
  input  logic       hit_right,
  output logic [7:0] ball_pos,
  output logic       dir,
  output logic       moving,
  output logic       miss_left,
  output logic       miss_right
);

  localparam int unsigned CW = (DIV > 2) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(DIV - 1);

  typedef enum logic {IDLE, MOVE} state_t;

  state_t        state;
  logic [CW-1:0] cnt;
  logic          tick;
  logic [8:0]    step;
  logic [8:0]    nxt_right;
  logic [8:0]    nxt_left;
  logic          right_wall;
  logic          left_wall;

  // Both candidates are 9 bits wide so neither direction can wrap in 8 bits.
  assign tick       = (cnt == CNT_LAST);
  assign step       = {7'd0, speed} + 9'd1;
  assign nxt_right  = {1'b0, ball_pos} + step;
  assign nxt_left   = {1'b0, ball_pos} - step;
  assign right_wall = (nxt_right >= {1'b0, POS_MAX});
  assign left_wall  = nxt_left[8] || (nxt_left == 9'd0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      cnt        <= '0;
      ball_pos   <= POS_CTR;
      dir        <= 1'b1;
      moving     <= 1'b0;
      miss_left  <= 1'b0;
      miss_right <= 1'b0;
    end else begin
      miss_left  <= 1'b0;
      miss_right <= 1'b0;
      case (state)
        IDLE: begin
          cnt      <= '0;
          ball_pos <= POS_CTR;
          moving   <= 1'b0;
          if (serve) begin
            state  <= MOVE;
            dir    <= serve_dir;
            moving <= 1'b1;
          end
        end
        MOVE: begin
          if (!tick) begin
            cnt <= cnt + 1'b1;
          end else begin
            cnt <= '0;
            if (dir) begin
              if (!right_wall) begin
                ball_pos <= nxt_right[7:0];
              end else if (hit_right) begin
                ball_pos <= POS_MAX;
                dir      <= 1'b0;
              end else begin
                miss_right <= 1'b1;
                ball_pos   <= POS_CTR;
                moving     <= 1'b0;
                state      <= IDLE;
              end
            end else begin
              if (!left_wall) begin
                ball_pos <= nxt_left[7:0];
              end else if (hit_left) begin
                ball_pos <= 8'd0;
                dir      <= 1'b1;
              end else begin
                miss_left <= 1'b1;
                ball_pos  <= POS_CTR;
                moving    <= 1'b0;
                state     <= IDLE;
              end
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
